// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the multicycle stage sequencer.
//   - stage_e: FSM state / stage_o encoding (the ALU compares against EXEC_STAGE)
//   - ITYPE_*: instruction format codes produced by decode
//   - fmt_ctrl_t / decode_fmt(): per-format operand strobes and writeback enable
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StOperand   = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd7
  } stage_e;

  // Plain stage constants for blocks that decode stage_o without importing the enum.
  localparam logic [2:0] FETCH_STAGE  = 3'd0;
  localparam logic [2:0] DECODE_STAGE = 3'd1;
  localparam logic [2:0] OPER_STAGE   = 3'd2;
  localparam logic [2:0] EXEC_STAGE   = 3'd3;
  localparam logic [2:0] MEM_STAGE    = 3'd4;
  localparam logic [2:0] WB_STAGE     = 3'd5;
  localparam logic [2:0] HALT_STAGE   = 3'd7;

  // Instruction formats; any other code is illegal.
  localparam logic [4:0] ITYPE_R = 5'd0;
  localparam logic [4:0] ITYPE_I = 5'd1;
  localparam logic [4:0] ITYPE_S = 5'd2;
  localparam logic [4:0] ITYPE_B = 5'd3;
  localparam logic [4:0] ITYPE_U = 5'd4;
  localparam logic [4:0] ITYPE_J = 5'd5;

  typedef struct packed {
    logic legal;
    logic rd_a;
    logic rd_b;
    logic rd_pass;
    logic rf_we;
  } fmt_ctrl_t;

  function automatic fmt_ctrl_t decode_fmt(logic [4:0] itype);
    fmt_ctrl_t c;
    c = '0;
    case (itype)
      ITYPE_R: c = '{legal: 1'b1, rd_a: 1'b1, rd_b: 1'b1, rd_pass: 1'b0, rf_we: 1'b1};
      ITYPE_I: c = '{legal: 1'b1, rd_a: 1'b1, rd_b: 1'b1, rd_pass: 1'b0, rf_we: 1'b1};
      ITYPE_S: c = '{legal: 1'b1, rd_a: 1'b1, rd_b: 1'b1, rd_pass: 1'b1, rf_we: 1'b0};
      ITYPE_B: c = '{legal: 1'b1, rd_a: 1'b1, rd_b: 1'b1, rd_pass: 1'b0, rf_we: 1'b0};
      ITYPE_U: c = '{legal: 1'b1, rd_a: 1'b0, rd_b: 1'b0, rd_pass: 1'b1, rf_we: 1'b1};
      ITYPE_J: c = '{legal: 1'b1, rd_a: 1'b0, rd_b: 1'b0, rd_pass: 1'b1, rf_we: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stage_sequencer_mem_wait_timer.sv
// Memory wait timer shared by the instruction-fetch and data-access waits.
// Counts cycles a request has been pending without ack and flags expiry on the
// MEM_TIMEOUT-th such cycle.
//   clk        in  clock
//   reset      in  synchronous active-high reset
//   clear_i    in  return the count to zero (no request pending, or ack seen)
//   count_en_i in  request pending and not acked this cycle
//   expired_o  out this is the MEM_TIMEOUT-th unacked cycle (combinational)
module stage_sequencer_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] count_q, count_d;

  // count_q holds the number of unacked cycles already elapsed, so the cycle
  // seen with count_q == MEM_TIMEOUT-1 is the last one allowed.
  assign expired_o = count_en_i && (count_q == LastCnt);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && !expired_o) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle control FSM sequencing one instruction at a time through
// FETCH, DECODE, OPERAND, EXECUTE, [MEMORY], WRITEBACK. All outputs registered.
//   clk, reset      clock; synchronous active-high reset
//   run_i           start a new fetch when idle in FETCH
//   imem_ack_i      instruction memory ack (honoured only while imem_req_o=1)
//   dmem_ack_i      data memory ack (honoured only while dmem_req_o=1)
//   itype_i         instruction format from decode
//   is_mem_i        load/store flag from decode
//   stage_o         current stage (state register)
//   imem_req_o      instruction fetch request
//   dmem_req_o      data access request
//   ir_load_o       IR capture pulse (DECODE cycle)
//   readin_a_o      ALU operand-A latch strobe (OPERAND cycle)
//   readin_b_o      ALU operand-B latch strobe (OPERAND cycle)
//   readin_pass_o   ALU pass-through latch strobe (OPERAND cycle)
//   rf_we_o         register file write enable (WRITEBACK cycle)
//   pc_inc_o        PC advance pulse (WRITEBACK cycle)
//   illegal_o       sticky: unknown itype or unused stage reached
//   bus_err_o       sticky: memory request timed out
//   retired_o       completed-instruction count, wraps silently
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned RET_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  input  logic [4:0]       itype_i,
  input  logic             is_mem_i,
  output logic [2:0]       stage_o,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             ir_load_o,
  output logic             readin_a_o,
  output logic             readin_b_o,
  output logic             readin_pass_o,
  output logic             rf_we_o,
  output logic             pc_inc_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [RET_W-1:0] retired_o
);

  stage_e           state_q, state_d;
  logic             imem_req_q, imem_req_d;
  logic             dmem_req_q, dmem_req_d;
  logic             ir_load_q, ir_load_d;
  logic             rd_a_q, rd_a_d;
  logic             rd_b_q, rd_b_d;
  logic             rd_pass_q, rd_pass_d;
  logic             rf_we_q, rf_we_d;
  logic             pc_inc_q, pc_inc_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [RET_W-1:0] retired_q, retired_d;

  fmt_ctrl_t fmt;
  logic      req_pending;
  logic      ack_taken;
  logic      timer_expired;

  assign fmt = decode_fmt(itype_i);

  // Acks only count while their own request is up; stray acks are dropped here.
  assign req_pending = imem_req_q | dmem_req_q;
  assign ack_taken   = (imem_req_q & imem_ack_i) | (dmem_req_q & dmem_ack_i);

  stage_sequencer_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!req_pending || ack_taken),
    .count_en_i(req_pending && !ack_taken),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    ir_load_d  = 1'b0;
    rd_a_d     = 1'b0;
    rd_b_d     = 1'b0;
    rd_pass_d  = 1'b0;
    rf_we_d    = 1'b0;
    pc_inc_d   = 1'b0;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    retired_d  = retired_q;

    case (state_q)
      StFetch: begin
        if (imem_req_q) begin
          // Ack is checked before expiry so a same-cycle ack wins.
          if (imem_ack_i) begin
            state_d   = StDecode;
            ir_load_d = 1'b1;
          end else if (timer_expired) begin
            bus_err_d = 1'b1;
            state_d   = StHalt;
          end else begin
            imem_req_d = 1'b1;
          end
        end else begin
          imem_req_d = run_i;
        end
      end

      StDecode: begin
        if (!fmt.legal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          // Strobes are registered on entry so they cover exactly the OPERAND cycle.
          state_d   = StOperand;
          rd_a_d    = fmt.rd_a;
          rd_b_d    = fmt.rd_b;
          rd_pass_d = fmt.rd_pass;
        end
      end

      StOperand: begin
        state_d = StExecute;
      end

      StExecute: begin
        if (is_mem_i) begin
          state_d    = StMemory;
          dmem_req_d = 1'b1;
        end else begin
          state_d   = StWriteback;
          rf_we_d   = fmt.rf_we;
          pc_inc_d  = 1'b1;
          retired_d = retired_q + RET_W'(1);
        end
      end

      StMemory: begin
        if (dmem_req_q && dmem_ack_i) begin
          state_d   = StWriteback;
          rf_we_d   = fmt.rf_we;
          pc_inc_d  = 1'b1;
          retired_d = retired_q + RET_W'(1);
        end else if (timer_expired) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          dmem_req_d = 1'b1;
        end
      end

      StWriteback: begin
        // Raising the next request on the way out keeps back-to-back issue at 5 cycles.
        state_d    = StFetch;
        imem_req_d = run_i;
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        // Unused encoding (6): treat as corruption.
        state_d   = StHalt;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      ir_load_q  <= 1'b0;
      rd_a_q     <= 1'b0;
      rd_b_q     <= 1'b0;
      rd_pass_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_inc_q   <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      ir_load_q  <= ir_load_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      rd_pass_q  <= rd_pass_d;
      rf_we_q    <= rf_we_d;
      pc_inc_q   <= pc_inc_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
      retired_q  <= retired_d;
    end
  end

  assign stage_o       = state_q;
  assign imem_req_o    = imem_req_q;
  assign dmem_req_o    = dmem_req_q;
  assign ir_load_o     = ir_load_q;
  assign readin_a_o    = rd_a_q;
  assign readin_b_o    = rd_b_q;
  assign readin_pass_o = rd_pass_q;
  assign rf_we_o       = rf_we_q;
  assign pc_inc_o      = pc_inc_q;
  assign illegal_o     = illegal_q;
  assign bus_err_o     = bus_err_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer (MEM_TIMEOUT=8, RET_W=4).
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_i, imem_ack_i, dmem_ack_i, is_mem_i;
  logic [4:0] itype_i;
  logic [2:0] stage_o;
  logic       imem_req_o, dmem_req_o, ir_load_o;
  logic       readin_a_o, readin_b_o, readin_pass_o;
  logic       rf_we_o, pc_inc_o, illegal_o, bus_err_o;
  logic [3:0] retired_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pulses;

  always #5 clk = ~clk;

  stage_sequencer #(
    .MEM_TIMEOUT(8),
    .RET_W      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run_i        (run_i),
    .imem_ack_i   (imem_ack_i),
    .dmem_ack_i   (dmem_ack_i),
    .itype_i      (itype_i),
    .is_mem_i     (is_mem_i),
    .stage_o      (stage_o),
    .imem_req_o   (imem_req_o),
    .dmem_req_o   (dmem_req_o),
    .ir_load_o    (ir_load_o),
    .readin_a_o   (readin_a_o),
    .readin_b_o   (readin_b_o),
    .readin_pass_o(readin_pass_o),
    .rf_we_o      (rf_we_o),
    .pc_inc_o     (pc_inc_o),
    .illegal_o    (illegal_o),
    .bus_err_o    (bus_err_o),
    .retired_o    (retired_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; run_i = 1'b0; imem_ack_i = 1'b1; dmem_ack_i = 1'b1;
    itype_i = ITYPE_R; is_mem_i = 1'b0;

    // 1: reset (acks ignored), then one RTYPE instruction
    tick();
    check("rst_stage", stage_o, 0);
    check("rst_outs", {imem_req_o, dmem_req_o, ir_load_o, readin_a_o, readin_b_o,
                       readin_pass_o, rf_we_o, pc_inc_o, illegal_o, bus_err_o}, 0);
    check("rst_retired", retired_o, 0);
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
    reset = 1'b0; run_i = 1'b1;
    tick();
    check("t1_fetch_stage", stage_o, 0);
    check("t1_fetch_req", imem_req_o, 1);
    imem_ack_i = 1'b1;
    tick();
    check("t1_decode_stage", stage_o, 1);
    check("t1_irload", {ir_load_o, imem_req_o}, 2'b10);
    imem_ack_i = 1'b0; run_i = 1'b0;
    tick();
    check("t1_oper_stage", stage_o, 2);
    check("t1_strobes", {readin_a_o, readin_b_o, readin_pass_o, ir_load_o}, 4'b1100);
    tick();
    check("t1_exec_stage", stage_o, 3);
    check("t1_strobes_off", {readin_a_o, readin_b_o, readin_pass_o}, 0);
    tick();
    check("t1_wb_stage", stage_o, 5);
    check("t1_wb_ctl", {rf_we_o, pc_inc_o}, 2'b11);
    check("t1_retired", retired_o, 1);
    tick();
    check("t1_back_fetch", stage_o, 0);
    check("t1_idle", {rf_we_o, pc_inc_o, imem_req_o}, 0);

    // Stray acks with no request pending are ignored
    imem_ack_i = 1'b1; dmem_ack_i = 1'b1;
    tick(); tick();
    check("stray_stage", stage_o, 0);
    check("stray_outs", {imem_req_o, dmem_req_o, ir_load_o}, 0);
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0;

    // 2: STYPE store, dmem ack on the 4th MEMORY cycle
    itype_i = ITYPE_S; is_mem_i = 1'b1; run_i = 1'b1;
    tick();
    check("t2_req", imem_req_o, 1);
    imem_ack_i = 1'b1;
    tick();
    check("t2_decode", stage_o, 1);
    imem_ack_i = 1'b0; run_i = 1'b0;
    tick();
    check("t2_strobes", {readin_a_o, readin_b_o, readin_pass_o}, 3'b111);
    tick();
    check("t2_exec", stage_o, 3);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_mem_hold", {stage_o, dmem_req_o}, {3'd4, 1'b1});
    end
    dmem_ack_i = 1'b1;
    tick();
    check("t2_wb_stage", stage_o, 5);
    check("t2_wb_ctl", {rf_we_o, pc_inc_o, dmem_req_o}, 3'b010);
    check("t2_retired", retired_o, 2);
    dmem_ack_i = 1'b0;
    tick();
    check("t2_back_fetch", stage_o, 0);

    // 3: illegal itype -> sticky HALT
    itype_i = 5'h1F; is_mem_i = 1'b0; run_i = 1'b1;
    tick();
    imem_ack_i = 1'b1;
    tick();
    check("t3_decode", stage_o, 1);
    imem_ack_i = 1'b0;
    tick();
    check("t3_halt", stage_o, 7);
    check("t3_illegal", illegal_o, 1);
    for (int k = 0; k < 20; k++) begin
      imem_ack_i = k[0]; dmem_ack_i = ~k[0];
      tick();
      check("t3_halt_stage", stage_o, 7);
      check("t3_halt_quiet", {imem_req_o, dmem_req_o, readin_a_o, readin_b_o, readin_pass_o,
                              illegal_o}, 6'b000001);
    end
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0;

    // 4: imem never acks -> bus error 8 cycles after request rises
    itype_i = ITYPE_R; reset = 1'b1; run_i = 1'b0;
    tick();
    check("t4_rst_clears", {illegal_o, stage_o}, 0);
    reset = 1'b0; run_i = 1'b1;
    tick();
    check("t4_req_rise", imem_req_o, 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t4_waiting", {imem_req_o, bus_err_o, stage_o}, {1'b1, 1'b0, 3'd0});
    end
    tick();
    check("t4_timeout", {imem_req_o, bus_err_o, stage_o}, {1'b0, 1'b1, 3'd7});

    // 4b: ack on the very cycle the timeout would fire -> ack wins
    reset = 1'b1; run_i = 1'b0;
    tick();
    reset = 1'b0; run_i = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) tick();
    check("t4b_still_req", imem_req_o, 1);
    imem_ack_i = 1'b1;
    tick();
    check("t4b_ack_wins", {stage_o, bus_err_o}, {3'd1, 1'b0});
    imem_ack_i = 1'b0; run_i = 1'b0;
    tick(); tick(); tick();
    check("t4b_wb", {stage_o, retired_o}, {3'd5, 4'd1});

    // 5: reset in MEMORY with a same-cycle dmem ack
    reset = 1'b1;
    tick();
    reset = 1'b0; itype_i = ITYPE_I; is_mem_i = 1'b1; run_i = 1'b1;
    tick();
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; run_i = 1'b0;
    tick(); tick(); tick();
    check("t5_in_mem", {stage_o, dmem_req_o}, {3'd4, 1'b1});
    reset = 1'b1; dmem_ack_i = 1'b1;
    tick();
    check("t5_stage", stage_o, 0);
    check("t5_dmem_drop", dmem_req_o, 0);
    check("t5_retired", retired_o, 0);
    check("t5_no_pulse", {rf_we_o, pc_inc_o}, 0);
    reset = 1'b0; dmem_ack_i = 1'b0;
    tick();
    check("t5_after", {stage_o, imem_req_o, dmem_req_o, pc_inc_o, rf_we_o}, 0);

    // 6: 17 back-to-back UTYPE with ack held high; retired wraps at 16
    reset = 1'b1;
    tick();
    reset = 1'b0; itype_i = ITYPE_U; is_mem_i = 1'b0; run_i = 1'b1; imem_ack_i = 1'b1;
    tick();
    check("t6_ack_no_req", {stage_o, imem_req_o}, {3'd0, 1'b1});
    pulses = 0;
    for (int k = 0; k < 79; k++) begin
      tick();
      if (pc_inc_o) pulses++;
    end
    check("t6_pulses16", pulses, 16);
    check("t6_wrap0", retired_o, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (pc_inc_o) pulses++;
    end
    check("t6_pulses17", pulses, 17);
    check("t6_retired", retired_o, 1);
    run_i = 1'b0; imem_ack_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
